arith_issue_queue: RTL and testbench
====================================

ARITH_ISSUE_QUEUE -- requirements
Module: arith_issue_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of reservation entries (power of two, 2..8).
REQ-002 The block SHALL have parameter PRN_W, default 7, meaning the physical register tag width.
REQ-003 The block SHALL have parameter ID_W, default 6, meaning the instruction id width.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset, named as follows:
  clk  in  1  clock; all state updates on posedge
  rst  in  1  synchronous active-high reset
REQ-005 The block SHALL have the following remaining ports:
  flush  in  1  discard all entries and pending issue
  disp_valid  in  1  dispatch request
  disp_ready  out  1  entry available
  disp_inst  in  32  instruction word
  disp_inst_id  in  ID_W  instruction id
  disp_out_prn  in  PRN_W  destination tag
  disp_src_prn  in  2xPRN_W  source tags, index 0 = Xn, 1 = Xm
  disp_src_rdy  in  2  source value already present
  disp_src_val  in  2x64  source values, valid where rdy
  wb_valid  in  1  writeback broadcast valid
  wb_prn  in  PRN_W  broadcast tag
  wb_data  in  64  broadcast value
  iss_valid  out  1  issue request to unit
  iss_ready  in  1  unit ready
  iss_inst  out  32  issued instruction word
  iss_inst_id  out  ID_W  issued id
  iss_out_prn  out  PRN_W  issued destination tag
  iss_op  out  2x64  issued operand values
  count  out  clog2(DEPTH)+1  occupied entries

Function
REQ-006 Each entry SHALL hold: valid, inst, inst_id, out_prn, per source {rdy, prn, value}, and an age rank.
REQ-007 disp_ready SHALL equal (count != DEPTH) and not flush, from registered state only; a slot freed this cycle is not reusable until the next cycle.
REQ-008 A dispatch SHALL be accepted when disp_valid and disp_ready are both high, writing the lowest-index free entry, with age rank youngest.
REQ-009 When wb_valid is high, every valid entry source with rdy=0 and prn==wb_prn SHALL set rdy=1 and capture wb_data at that edge.
REQ-010 A dispatch accepted in the same cycle as a wb with wb_prn equal to a source tag whose disp_src_rdy=0 SHALL capture wb_data for that source (no lost wakeup).
REQ-011 An entry SHALL be eligible when valid and both sources are rdy in registered state; a source woken at edge t makes the entry eligible for selection in the cycle after t.
REQ-012 The output stage SHALL be a single register; it loads when empty, or when iss_valid and iss_ready are both high, with the oldest eligible entry, which is freed at the same edge.
REQ-013 Minimum latency SHALL be one cycle: dispatch with both rdy accepted at edge t, empty queue, gives iss_valid=1 in cycle t+1.
REQ-014 While iss_valid=1 and iss_ready=0, all iss_* outputs SHALL hold stable.
REQ-015 Back-to-back issue SHALL be sustained: with iss_ready held high and eligible entries, one issue per cycle.
REQ-016 Age ranks SHALL stay a strict total order over valid entries; on free, all younger ranks decrement by one.
REQ-017 count SHALL equal the number of valid entries, excluding the output register; simultaneous accept and free leaves count unchanged.
REQ-018 With a flush, all entries SHALL be invalidated and iss_valid cleared at that edge; a same-cycle dispatch is dropped, and a same-cycle handshake is still considered completed by the unit.

Reset
REQ-019 With rst high at a clock edge, every entry valid SHALL be 0, iss_valid=0, count=0, and disp_ready SHALL be 1 in the following cycle; rst dominates flush, dispatch and wb.
REQ-020 iss_inst, iss_inst_id, iss_out_prn and iss_op SHALL reset to 0.

Verification
REQ-021 Dispatch ADD imm, src0 rdy, value 5, iss_ready=1 -> next cycle iss_valid=1, iss_op[0]=5, correct id/prn, count returns 0.
REQ-022 Dispatch A (src1 prn 9 not rdy) then B (all rdy) -> B issues first; wb prn 9 value 0x10 -> A issues the cycle after eligibility with op[1]=0x10.
REQ-023 Fill 4 entries with iss_ready=0 -> disp_ready=0 with count=4; payload stable; raise iss_ready -> oldest issues, disp_ready=1 the next cycle.
REQ-024 Dispatch with src0 prn 12 not rdy, while wb_prn=12, wb_data=0xABCD in the same cycle -> entry captures 0xABCD and issues without a further wb.
REQ-025 Flush with 3 valid entries, iss_valid=1 and a same-cycle dispatch -> next cycle count=0, iss_valid=0, the dispatched instruction never issues.
REQ-026 rst asserted mid-stream with 2 entries and a pending issue -> next cycle all outputs are at reset values; the first dispatch after reset issues normally.

Source files
------------

// File: rtl/arith_issue_queue_if.sv
// Dispatch, writeback and issue bundle shared by the arithmetic issue queue and its driver.
interface arith_issue_queue_if #(
   parameter int DEPTH = 4,
   parameter int PRN_W = 7,
   parameter int ID_W  = 6
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  flush;
   logic                  disp_valid;
   logic                  disp_ready;
   logic [31:0]           disp_inst;
   logic [ID_W-1:0]       disp_inst_id;
   logic [PRN_W-1:0]      disp_out_prn;
   logic [1:0][PRN_W-1:0] disp_src_prn;
   logic [1:0]            disp_src_rdy;
   logic [1:0][63:0]      disp_src_val;
   logic                  wb_valid;
   logic [PRN_W-1:0]      wb_prn;
   logic [63:0]           wb_data;
   logic                  iss_valid;
   logic                  iss_ready;
   logic [31:0]           iss_inst;
   logic [ID_W-1:0]       iss_inst_id;
   logic [PRN_W-1:0]      iss_out_prn;
   logic [1:0][63:0]      iss_op;
   logic [CNT_W-1:0]      count;

   modport master (
      output flush, disp_valid, disp_inst, disp_inst_id, disp_out_prn,
             disp_src_prn, disp_src_rdy, disp_src_val,
             wb_valid, wb_prn, wb_data, iss_ready,
      input  disp_ready, iss_valid, iss_inst, iss_inst_id, iss_out_prn, iss_op, count
   );

   modport slave (
      input  flush, disp_valid, disp_inst, disp_inst_id, disp_out_prn,
             disp_src_prn, disp_src_rdy, disp_src_val,
             wb_valid, wb_prn, wb_data, iss_ready,
      output disp_ready, iss_valid, iss_inst, iss_inst_id, iss_out_prn, iss_op, count
   );
endinterface

// File: rtl/arith_issue_queue.sv
// Arithmetic reservation station: holds dispatched instructions until both source
// operands are present, then issues the oldest ready one through a single output register.
module arith_issue_queue #(
   parameter int DEPTH = 4,
   parameter int PRN_W = 7,
   parameter int ID_W  = 6
) (
   input  logic                clk,
   input  logic                rst,
   arith_issue_queue_if.slave  q
);
   localparam int AGE_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   // entry state (rank 0 = oldest)
   logic [DEPTH-1:0]      r_vld;
   logic [AGE_W-1:0]      r_age  [DEPTH];
   logic [1:0]            r_rdy  [DEPTH];
   logic [31:0]           r_inst [DEPTH];
   logic [ID_W-1:0]       r_id   [DEPTH];
   logic [PRN_W-1:0]      r_oprn [DEPTH];
   logic [1:0][PRN_W-1:0] r_prn  [DEPTH];
   logic [1:0][63:0]      r_val  [DEPTH];

   // output register
   logic                  r_iss_valid;
   logic [31:0]           r_iss_inst;
   logic [ID_W-1:0]       r_iss_id;
   logic [PRN_W-1:0]      r_iss_oprn;
   logic [1:0][63:0]      r_iss_op;

   logic [CNT_W-1:0]      w_count;
   logic                  w_free_hit;
   logic [AGE_W-1:0]      w_free_idx;
   logic                  w_sel_hit;
   logic [AGE_W-1:0]      w_sel_idx;
   logic [AGE_W-1:0]      w_sel_age;
   logic                  w_disp_ready;
   logic                  w_accept;
   logic                  w_load;
   logic                  w_issue;
   logic [AGE_W-1:0]      w_new_age;
   logic [1:0]            w_disp_rdy;
   logic [1:0][63:0]      w_disp_val;
   logic [1:0]            w_wake [DEPTH];

   // Occupancy, lowest free slot and oldest eligible entry, all from registered state
   always_comb begin
      w_count    = '0;
      w_free_hit = 1'b0;
      w_free_idx = '0;
      w_sel_hit  = 1'b0;
      w_sel_idx  = '0;
      w_sel_age  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i]) begin
            w_count = w_count + CNT_W'(1);
         end else if (!w_free_hit) begin
            w_free_hit = 1'b1;
            w_free_idx = AGE_W'(i);
         end
         if (r_vld[i] && (&r_rdy[i]) && (!w_sel_hit || (r_age[i] < w_sel_age))) begin
            w_sel_hit = 1'b1;
            w_sel_idx = AGE_W'(i);
            w_sel_age = r_age[i];
         end
      end
   end

   // Handshakes, new-entry rank and same-cycle writeback capture for the dispatched sources
   always_comb begin
      w_disp_ready = (w_count != CNT_W'(DEPTH)) && !q.flush;
      w_accept     = q.disp_valid && w_disp_ready;
      w_load       = !r_iss_valid || q.iss_ready;
      w_issue      = w_load && w_sel_hit && !q.flush;
      // the slot freed by this cycle's issue shifts the youngest rank down by one
      w_new_age    = AGE_W'(w_count - CNT_W'(w_issue));
      for (int s = 0; s < 2; s++) begin
         w_disp_rdy[s] = q.disp_src_rdy[s] ||
                         (q.wb_valid && (q.disp_src_prn[s] == q.wb_prn));
         w_disp_val[s] = q.disp_src_rdy[s] ? q.disp_src_val[s] : q.wb_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
         for (int s = 0; s < 2; s++) begin
            w_wake[i][s] = q.wb_valid && r_vld[i] && !r_rdy[i][s] &&
                           (r_prn[i][s] == q.wb_prn);
         end
      end
   end

   // Entry control: valid bits, source ready flags and age ranks
   always_ff @(posedge clk) begin
      if (rst || q.flush) begin
         r_vld <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_rdy[i] <= '0;
            r_age[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
               if (w_issue && (AGE_W'(i) == w_sel_idx)) begin
                  r_vld[i] <= 1'b0;
               end else if (w_issue && (r_age[i] > w_sel_age)) begin
                  r_age[i] <= r_age[i] - AGE_W'(1);
               end
               r_rdy[i] <= r_rdy[i] | w_wake[i];
            end else if (w_accept && (AGE_W'(i) == w_free_idx)) begin
               r_vld[i] <= 1'b1;
               r_age[i] <= w_new_age;
               r_rdy[i] <= w_disp_rdy;
            end
         end
      end
   end

   // Entry payload: written on dispatch, operand values captured on wakeup
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!r_vld[i] && w_accept && (AGE_W'(i) == w_free_idx)) begin
            r_inst[i] <= q.disp_inst;
            r_id[i]   <= q.disp_inst_id;
            r_oprn[i] <= q.disp_out_prn;
            r_prn[i]  <= q.disp_src_prn;
            r_val[i]  <= w_disp_val;
         end else begin
            for (int s = 0; s < 2; s++) begin
               if (w_wake[i][s]) begin
                  r_val[i][s] <= q.wb_data;
               end
            end
         end
      end
   end

   // Output register: refill when empty or when the unit takes the current instruction
   always_ff @(posedge clk) begin
      if (rst) begin
         r_iss_valid <= 1'b0;
         r_iss_inst  <= '0;
         r_iss_id    <= '0;
         r_iss_oprn  <= '0;
         r_iss_op    <= '0;
      end else if (q.flush) begin
         r_iss_valid <= 1'b0;
      end else if (w_load) begin
         r_iss_valid <= w_sel_hit;
         if (w_sel_hit) begin
            r_iss_inst <= r_inst[w_sel_idx];
            r_iss_id   <= r_id[w_sel_idx];
            r_iss_oprn <= r_oprn[w_sel_idx];
            r_iss_op   <= r_val[w_sel_idx];
         end
      end
   end

   assign q.disp_ready  = w_disp_ready;
   assign q.count       = w_count;
   assign q.iss_valid   = r_iss_valid;
   assign q.iss_inst    = r_iss_inst;
   assign q.iss_inst_id = r_iss_id;
   assign q.iss_out_prn = r_iss_oprn;
   assign q.iss_op      = r_iss_op;
endmodule

// File: tb/tb_arith_issue_queue.sv
// Self-checking bench for arith_issue_queue: directed scenarios plus a randomized run,
// all compared against an age-ordered queue model of the reservation station.
module tb_arith_issue_queue;
   localparam int DEPTH = 4;
   localparam int PRN_W = 7;
   localparam int ID_W  = 6;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   arith_issue_queue_if #(.DEPTH(DEPTH), .PRN_W(PRN_W), .ID_W(ID_W)) q ();

   arith_issue_queue #(.DEPTH(DEPTH), .PRN_W(PRN_W), .ID_W(ID_W)) dut (
      .clk (clk),
      .rst (rst),
      .q   (q)
   );

   typedef struct packed {
      logic [31:0]           inst;
      logic [ID_W-1:0]       id;
      logic [PRN_W-1:0]      oprn;
      logic [1:0]            rdy;
      logic [1:0][PRN_W-1:0] prn;
      logic [1:0][63:0]      val;
   } ent_t;

   // model: queue in age order (index 0 = oldest) plus the output register
   ent_t m_q[$];
   logic m_iv = 1'b0;
   ent_t m_out = '0;

   task automatic idle();
      q.flush        = 1'b0;
      q.disp_valid   = 1'b0;
      q.disp_inst    = '0;
      q.disp_inst_id = '0;
      q.disp_out_prn = '0;
      q.disp_src_prn = '0;
      q.disp_src_rdy = '0;
      q.disp_src_val = '0;
      q.wb_valid     = 1'b0;
      q.wb_prn       = '0;
      q.wb_data      = '0;
   endtask

   task automatic disp(input logic [31:0] inst, input logic [ID_W-1:0] id,
                       input logic [PRN_W-1:0] oprn, input logic [PRN_W-1:0] p0,
                       input logic [PRN_W-1:0] p1, input logic [1:0] rdy,
                       input logic [63:0] v0, input logic [63:0] v1);
      q.disp_valid      = 1'b1;
      q.disp_inst       = inst;
      q.disp_inst_id    = id;
      q.disp_out_prn    = oprn;
      q.disp_src_prn[0] = p0;
      q.disp_src_prn[1] = p1;
      q.disp_src_rdy    = rdy;
      q.disp_src_val[0] = v0;
      q.disp_src_val[1] = v1;
   endtask

   // advance the model by one edge using the inputs now driven, then clock the DUT
   task automatic cycle();
      int   sel;
      ent_t e;
      logic acc;
      if (rst) begin
         m_q.delete();
         m_iv  = 1'b0;
         m_out = '0;
      end else if (q.flush) begin
         m_q.delete();
         m_iv = 1'b0;
      end else begin
         acc = q.disp_valid && (m_q.size() != DEPTH);
         if (!m_iv || q.iss_ready) begin
            sel = -1;
            for (int i = 0; i < m_q.size(); i++)
               if (sel < 0 && m_q[i].rdy == 2'b11) sel = i;
            if (sel >= 0) begin
               m_iv  = 1'b1;
               m_out = m_q[sel];
               m_q.delete(sel);
            end else begin
               m_iv = 1'b0;
            end
         end
         for (int i = 0; i < m_q.size(); i++) begin
            e = m_q[i];
            for (int s = 0; s < 2; s++)
               if (q.wb_valid && !e.rdy[s] && e.prn[s] == q.wb_prn) begin
                  e.rdy[s] = 1'b1;
                  e.val[s] = q.wb_data;
               end
            m_q[i] = e;
         end
         if (acc) begin
            e.inst = q.disp_inst;
            e.id   = q.disp_inst_id;
            e.oprn = q.disp_out_prn;
            e.prn  = q.disp_src_prn;
            for (int s = 0; s < 2; s++) begin
               if (q.disp_src_rdy[s]) begin
                  e.rdy[s] = 1'b1;
                  e.val[s] = q.disp_src_val[s];
               end else if (q.wb_valid && q.disp_src_prn[s] == q.wb_prn) begin
                  e.rdy[s] = 1'b1;
                  e.val[s] = q.wb_data;
               end else begin
                  e.rdy[s] = 1'b0;
                  e.val[s] = q.disp_src_val[s];
               end
            end
            m_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      disp(32'h1, 6'd1, 7'd1, 7'd1, 7'd2, 2'b11, 64'd1, 64'd2);
      q.flush = 1'b1; q.wb_valid = 1'b1; q.iss_ready = 1'b0;
      cycle();
      cycle();
      idle();
      #1;
      checks++; if (q.iss_valid !== 1'b0) begin failures++; $display("FAIL reset_iss_valid got=%0b exp=0", q.iss_valid); end
      checks++; if (q.count !== CNT_W'(0)) begin failures++; $display("FAIL reset_count got=%0d exp=0", q.count); end
      checks++; if (q.disp_ready !== 1'b1) begin failures++; $display("FAIL reset_disp_ready got=%0b exp=1", q.disp_ready); end
      checks++; if ({q.iss_inst, q.iss_inst_id, q.iss_out_prn} !== '0) begin failures++; $display("FAIL reset_payload got=%h/%h/%h exp=0", q.iss_inst, q.iss_inst_id, q.iss_out_prn); end
      checks++; if (q.iss_op !== '0) begin failures++; $display("FAIL reset_op got=%h exp=0", q.iss_op); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      q.iss_ready = 1'b1;
      disp(32'h00500093, 6'd3, 7'd20, 7'd1, 7'd0, 2'b11, 64'd5, 64'd0);
      cycle();
      idle();
      checks++; if (q.count !== CNT_W'(1) || q.iss_valid !== 1'b0) begin failures++; $display("FAIL single_stage1 count=%0d iss_valid=%0b exp count=1 iss_valid=0", q.count, q.iss_valid); end
      cycle();
      checks++; if (q.iss_valid !== 1'b1) begin failures++; $display("FAIL single_iss_valid got=%0b exp=1", q.iss_valid); end
      checks++; if (q.iss_op[0] !== 64'd5 || q.iss_op[0] !== m_out.val[0]) begin failures++; $display("FAIL single_op0 got=%0d exp=5", q.iss_op[0]); end
      checks++; if (q.iss_inst_id !== 6'd3 || q.iss_out_prn !== 7'd20 || q.iss_inst !== 32'h00500093) begin failures++; $display("FAIL single_tag id=%0d prn=%0d inst=%h exp id=3 prn=20 inst=00500093", q.iss_inst_id, q.iss_out_prn, q.iss_inst); end
      checks++; if (q.count !== CNT_W'(0)) begin failures++; $display("FAIL single_count got=%0d exp=0", q.count); end
      cycle();
      checks++; if (q.iss_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0b exp=0", q.iss_valid); end
   endtask

   task automatic test_wakeup_order();
      q.iss_ready = 1'b1;
      disp(32'hA, 6'd1, 7'd30, 7'd2, 7'd9, 2'b01, 64'd7, 64'hBAD);
      cycle();
      disp(32'hB, 6'd2, 7'd31, 7'd3, 7'd4, 2'b11, 64'd1, 64'd2);
      cycle();
      idle();
      cycle();
      checks++; if (q.iss_valid !== 1'b1 || q.iss_inst !== 32'hB) begin failures++; $display("FAIL order_first iss_valid=%0b inst=%h exp 1/B", q.iss_valid, q.iss_inst); end
      q.wb_valid = 1'b1; q.wb_prn = 7'd9; q.wb_data = 64'h10;
      cycle();
      idle();
      checks++; if (q.iss_valid !== m_iv || q.iss_valid !== 1'b0) begin failures++; $display("FAIL order_gap iss_valid=%0b exp=0", q.iss_valid); end
      cycle();
      checks++; if (q.iss_valid !== 1'b1 || q.iss_inst !== 32'hA) begin failures++; $display("FAIL order_second iss_valid=%0b inst=%h exp 1/A", q.iss_valid, q.iss_inst); end
      checks++; if (q.iss_op[1] !== 64'h10 || q.iss_op[0] !== 64'd7) begin failures++; $display("FAIL order_ops op1=%h op0=%h exp 10/7", q.iss_op[1], q.iss_op[0]); end
      cycle();
   endtask

   task automatic test_same_cycle_wb();
      q.iss_ready = 1'b1;
      disp(32'hC, 6'd4, 7'd40, 7'd12, 7'd3, 2'b10, 64'hDEAD, 64'h33);
      q.wb_valid = 1'b1; q.wb_prn = 7'd12; q.wb_data = 64'hABCD;
      cycle();
      idle();
      cycle();
      checks++; if (q.iss_valid !== 1'b1 || q.iss_inst_id !== 6'd4) begin failures++; $display("FAIL samewb_issue iss_valid=%0b id=%0d exp 1/4", q.iss_valid, q.iss_inst_id); end
      checks++; if (q.iss_op[0] !== 64'hABCD || q.iss_op[1] !== 64'h33) begin failures++; $display("FAIL samewb_ops op0=%h op1=%h exp ABCD/33", q.iss_op[0], q.iss_op[1]); end
      cycle();
   endtask

   task automatic test_full();
      q.iss_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         disp(32'd100 + k, ID_W'(10 + k), 7'd50, 7'd1, 7'd2, 2'b11, 64'(k), 64'(k + 1));
         cycle();
      end
      disp(32'd999, 6'd20, 7'd51, 7'd1, 7'd2, 2'b11, 64'd0, 64'd0);
      #1;
      checks++; if (q.count !== CNT_W'(4) || q.count !== CNT_W'(m_q.size())) begin failures++; $display("FAIL full_count got=%0d exp=4", q.count); end
      checks++; if (q.disp_ready !== 1'b0) begin failures++; $display("FAIL full_disp_ready got=%0b exp=0", q.disp_ready); end
      for (int k = 0; k < 3; k++) begin
         cycle();
         checks++; if (q.iss_valid !== 1'b1 || q.iss_inst_id !== 6'd10 || q.iss_op !== m_out.val || q.count !== CNT_W'(4)) begin failures++; $display("FAIL full_hold k=%0d valid=%0b id=%0d count=%0d exp 1/10/4", k, q.iss_valid, q.iss_inst_id, q.count); end
      end
      idle();
      q.iss_ready = 1'b1;
      cycle();
      checks++; if (q.iss_inst_id !== 6'd11 || q.count !== CNT_W'(3)) begin failures++; $display("FAIL full_release id=%0d count=%0d exp 11/3", q.iss_inst_id, q.count); end
      checks++; if (q.disp_ready !== 1'b1) begin failures++; $display("FAIL full_ready_again got=%0b exp=1", q.disp_ready); end
      for (int k = 0; k < 5; k++) cycle();
      checks++; if (q.iss_valid !== 1'b0 || q.count !== CNT_W'(0)) begin failures++; $display("FAIL full_drain valid=%0b count=%0d exp 0/0", q.iss_valid, q.count); end
   endtask

   task automatic test_back_to_back();
      q.iss_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         disp(32'd200 + k, ID_W'(40 + k), 7'd60, 7'd5, 7'd6, 2'b11, 64'(k * 3), 64'd9);
         cycle();
         if (k >= 1) begin
            checks++; if (q.iss_valid !== 1'b1 || q.iss_inst_id !== ID_W'(40 + k - 1)) begin failures++; $display("FAIL b2b k=%0d valid=%0b id=%0d exp 1/%0d", k, q.iss_valid, q.iss_inst_id, 40 + k - 1); end
         end
      end
      idle();
      cycle();
      checks++; if (q.iss_valid !== 1'b1 || q.iss_inst_id !== 6'd45) begin failures++; $display("FAIL b2b_last valid=%0b id=%0d exp 1/45", q.iss_valid, q.iss_inst_id); end
      cycle();
      checks++; if (q.iss_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0b exp=0", q.iss_valid); end
   endtask

   task automatic test_flush();
      q.iss_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         disp(32'd300 + k, ID_W'(50 + k), 7'd70, 7'd1, 7'd2, 2'b11, 64'd1, 64'd1);
         cycle();
      end
      checks++; if (q.count !== CNT_W'(3) || q.iss_valid !== 1'b1) begin failures++; $display("FAIL flush_pre count=%0d valid=%0b exp 3/1", q.count, q.iss_valid); end
      disp(32'hF1, 6'd63, 7'd71, 7'd1, 7'd2, 2'b11, 64'd1, 64'd1);
      q.flush = 1'b1;
      q.iss_ready = 1'b1;
      cycle();
      checks++; if (q.count !== CNT_W'(0) || q.iss_valid !== 1'b0) begin failures++; $display("FAIL flush_clear count=%0d valid=%0b exp 0/0", q.count, q.iss_valid); end
      idle();
      for (int k = 0; k < 4; k++) begin
         cycle();
         checks++; if (q.iss_valid !== 1'b0 || q.count !== CNT_W'(0)) begin failures++; $display("FAIL flush_dropped k=%0d valid=%0b id=%0d exp no issue", k, q.iss_valid, q.iss_inst_id); end
      end
   endtask

   task automatic test_reset_mid();
      q.iss_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         disp(32'd400 + k, ID_W'(1 + k), 7'd80, 7'd1, 7'd2, 2'b11, 64'd4, 64'd4);
         cycle();
      end
      disp(32'hEE, 6'd7, 7'd81, 7'd1, 7'd2, 2'b11, 64'd3, 64'd3);
      q.wb_valid = 1'b1; q.wb_prn = 7'd1; q.wb_data = 64'd5;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      idle();
      #1;
      checks++; if (q.iss_valid !== 1'b0 || q.count !== CNT_W'(0) || q.disp_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ctrl valid=%0b count=%0d ready=%0b exp 0/0/1", q.iss_valid, q.count, q.disp_ready); end
      checks++; if ({q.iss_inst, q.iss_inst_id, q.iss_out_prn, q.iss_op} !== '0) begin failures++; $display("FAIL rstmid_payload inst=%h id=%0d prn=%0d exp 0", q.iss_inst, q.iss_inst_id, q.iss_out_prn); end
      q.iss_ready = 1'b1;
      disp(32'h99, 6'd9, 7'd90, 7'd3, 7'd4, 2'b11, 64'd11, 64'd12);
      cycle();
      idle();
      cycle();
      checks++; if (q.iss_valid !== 1'b1 || q.iss_inst_id !== 6'd9 || q.iss_inst !== 32'h99 || q.iss_op[1] !== 64'd12) begin failures++; $display("FAIL rstmid_after valid=%0b id=%0d inst=%h exp 1/9/99", q.iss_valid, q.iss_inst_id, q.iss_inst); end
      cycle();
   endtask

   task automatic test_random();
      logic exp_rdy;
      for (int c = 0; c < 600; c++) begin
         idle();
         if ($urandom_range(0, 9) < 6)
            disp($urandom, ID_W'($urandom), PRN_W'($urandom), PRN_W'($urandom_range(0, 15)),
                 PRN_W'($urandom_range(0, 15)), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
         q.wb_valid  = ($urandom_range(0, 1) == 1);
         q.wb_prn    = PRN_W'($urandom_range(0, 15));
         q.wb_data   = {$urandom, $urandom};
         q.iss_ready = ($urandom_range(0, 9) < 6);
         q.flush     = ($urandom_range(0, 49) == 0);
         cycle();
         exp_rdy = (m_q.size() != DEPTH) && !q.flush;
         checks++; if (q.iss_valid !== m_iv) begin failures++; $display("FAIL rnd_iss_valid cyc=%0d got=%0b exp=%0b", c, q.iss_valid, m_iv); end
         checks++; if (q.count !== CNT_W'(m_q.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, q.count, m_q.size()); end
         checks++; if (q.disp_ready !== exp_rdy) begin failures++; $display("FAIL rnd_disp_ready cyc=%0d got=%0b exp=%0b", c, q.disp_ready, exp_rdy); end
         if (m_iv) begin
            checks++; if ({q.iss_inst, q.iss_inst_id, q.iss_out_prn, q.iss_op} !== {m_out.inst, m_out.id, m_out.oprn, m_out.val}) begin failures++; $display("FAIL rnd_payload cyc=%0d got id=%0d inst=%h op=%h exp id=%0d inst=%h op=%h", c, q.iss_inst_id, q.iss_inst, q.iss_op, m_out.id, m_out.inst, m_out.val); end
         end
      end
   endtask

   initial begin
      idle();
      q.iss_ready = 1'b0;
      test_reset();
      test_single();
      test_wakeup_order();
      test_same_cycle_wb();
      test_full();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end
endmodule
